// File: rtl/ldpc_frame_ctrl_if.sv
// Purpose: bundles the upstream bit stream, parity-encoder control and codeword output of ldpc_frame_ctrl.
// Latency: none (wires only).
// Backpressure: in_ready throttles upstream; the codeword output is push-only.
interface ldpc_frame_ctrl_if;
  // upstream information bits
  logic        in_valid;
  logic        in_data;
  logic        in_ready;
  // parity encoder side
  logic        enc_clr;
  logic        enc_din_valid;
  logic        enc_din;
  logic [12:0] enc_counter;
  logic [8:0]  enc_out_addr;
  logic        enc_check_en;
  logic        enc_dout;
  // codeword stream
  logic        out_valid;
  logic        out_data;
  logic        out_sof;
  logic        out_eof;
  logic        frame_done;

  // controller side
  modport master (
    input  in_valid, in_data, enc_dout,
    output in_ready, enc_clr, enc_din_valid, enc_din, enc_counter,
           enc_out_addr, enc_check_en, out_valid, out_data, out_sof,
           out_eof, frame_done
  );

  // environment side (source, encoder, sink)
  modport slave (
    output in_valid, in_data, enc_dout,
    input  in_ready, enc_clr, enc_din_valid, enc_din, enc_counter,
           enc_out_addr, enc_check_en, out_valid, out_data, out_sof,
           out_eof, frame_done
  );
endinterface

// File: rtl/ldpc_frame_ctrl.sv
// Purpose: sequences one 4320-bit LDPC frame through the parity encoder and streams out its 360 parity bits
//          (plus the 4320 systematic bits when LDPC_SYS_OUT_EN is defined).
// Latency: 4 clear cycles before the first accepted bit; output bits appear 1 cycle after acceptance / readout.
// Backpressure: in_ready=1 only in INFO, so upstream stalls freely; the output stream is push-only.
module ldpc_frame_ctrl (
  input  logic              clk,
  input  logic              rst,
  ldpc_frame_ctrl_if.master bus
);

  localparam logic [12:0] LAST_INFO_IDX = 13'd4319;
  localparam logic [8:0]  FIRST_PAR_ADR = 9'd359;
  localparam logic [1:0]  LAST_CLR_CYC  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_INFO,
    S_DRAIN,
    S_PARITY,
    S_TAIL
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;       // index of the next information bit
  logic [8:0]  addr_q, addr_d;     // parity select, stays 0 outside PARITY
  logic [1:0]  clr_q, clr_d;       // cycles spent in CLEAR
  logic        par_vld_q, par_vld_d;
  logic        par_sof_q, par_sof_d;
  logic        par_eof_q, par_eof_d;
  logic        accept;

`ifdef LDPC_SYS_OUT_EN
  logic        sys_vld_q, sys_vld_d;
  logic        sys_dat_q, sys_dat_d;
  logic        sys_sof_q, sys_sof_d;
`endif

  // Bit accepted this cycle: only INFO ever raises in_ready.
  always_comb begin
    accept = (state_q == S_INFO) && bus.in_valid;
  end

  // Next-state logic for the frame sequencer and its counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    clr_d   = clr_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        addr_d = '0;
        clr_d  = '0;
        // The request bit is not consumed here; it is taken again in INFO.
        if (bus.in_valid) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr_d = clr_q + 2'd1;
        if (clr_q == LAST_CLR_CYC) begin
          state_d = S_INFO;
        end
      end
      S_INFO: begin
        if (accept) begin
          if (cnt_q == LAST_INFO_IDX) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end
      end
      S_DRAIN: begin
        // Last XOR lands in the encoder during this cycle; readout starts next.
        addr_d  = FIRST_PAR_ADR;
        state_d = S_PARITY;
      end
      S_PARITY: begin
        if (addr_q == 9'd0) begin
          state_d = S_TAIL;
        end else begin
          addr_d = addr_q - 9'd1;
        end
      end
      S_TAIL: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output-stream flags: the encoder registers its parity bit, so every
  // PARITY cycle yields one output bit on the following cycle.
  always_comb begin
    par_vld_d = (state_q == S_PARITY);
    par_eof_d = (state_q == S_PARITY) && (addr_q == 9'd0);
`ifdef LDPC_SYS_OUT_EN
    // Frame starts with systematic bit 0, so parity never carries sof.
    par_sof_d = 1'b0;
    sys_vld_d = accept;
    sys_dat_d = accept & bus.in_data;
    sys_sof_d = accept && (cnt_q == 13'd0);
`else
    par_sof_d = (state_q == S_PARITY) && (addr_q == FIRST_PAR_ADR);
`endif
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      clr_q     <= '0;
      par_vld_q <= 1'b0;
      par_sof_q <= 1'b0;
      par_eof_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      clr_q     <= clr_d;
      par_vld_q <= par_vld_d;
      par_sof_q <= par_sof_d;
      par_eof_q <= par_eof_d;
    end
  end

`ifdef LDPC_SYS_OUT_EN
  // Systematic bit delay stage, one cycle behind acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sys_vld_q <= 1'b0;
      sys_dat_q <= 1'b0;
      sys_sof_q <= 1'b0;
    end else begin
      sys_vld_q <= sys_vld_d;
      sys_dat_q <= sys_dat_d;
      sys_sof_q <= sys_sof_d;
    end
  end
`endif

  // Encoder control and codeword stream decoded from registered state.
  always_comb begin
    bus.in_ready      = (state_q == S_INFO);
    bus.enc_clr       = (state_q == S_CLEAR);
    bus.enc_din_valid = accept;
    bus.enc_din       = accept & bus.in_data;
    bus.enc_counter   = cnt_q;
    bus.enc_out_addr  = addr_q;
    bus.enc_check_en  = (state_q == S_PARITY);
    bus.frame_done    = (state_q == S_TAIL);
    bus.out_eof       = par_eof_q;
`ifdef LDPC_SYS_OUT_EN
    bus.out_valid     = par_vld_q | sys_vld_q;
    bus.out_data      = (par_vld_q & bus.enc_dout) | (sys_vld_q & sys_dat_q);
    bus.out_sof       = par_sof_q | sys_sof_q;
`else
    bus.out_valid     = par_vld_q;
    bus.out_data      = par_vld_q & bus.enc_dout;
    bus.out_sof       = par_sof_q;
`endif
  end

endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// Purpose: scoreboard bench for ldpc_frame_ctrl with a behavioural parity encoder attached.
// Latency: expected output bits are queued by the driver and popped by the monitor when out_valid is seen.
// Backpressure: stalls are exercised by toggling in_valid; the output side is push-only.
module tb_ldpc_frame_ctrl;

`ifdef LDPC_SYS_OUT_EN
  localparam bit SYS = 1'b1;
`else
  localparam bit SYS = 1'b0;
`endif
  localparam int FRAME_OUT = SYS ? 4680 : 360;

  typedef struct packed {
    logic d;
    logic sof;
    logic eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ldpc_frame_ctrl_if bus ();

  ldpc_frame_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nout = 0;
  int   ndone = 0;
  int   last_done = -1;
  int   exp_addr = 359;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pseudo ROM row: three parity columns touched by information bit idx.
  function automatic logic [359:0] rom_row(input int idx);
    logic [359:0] r;
    r = '0;
    r[(idx * 37) % 360]        = 1'b1;
    r[(idx * 113 + 7) % 360]   = r[(idx * 113 + 7) % 360] ^ 1'b1;
    r[(idx * 11 + 200) % 360]  = r[(idx * 11 + 200) % 360] ^ 1'b1;
    return r;
  endfunction

  function automatic logic pat_bit(input int pat, input int i);
    case (pat)
      1:       return (i == 0);
      2:       return ((i % 97) == 3);
      3:       return ((i % 5) == 0);
      4:       return ((i % 7) == 1);
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural encoder: starts with junk so a skipped clear is visible.
  logic [359:0] enc_par = {360{1'b1}};
  always @(posedge clk) begin
    if (bus.enc_clr) enc_par <= '0;
    else if (bus.enc_din_valid && bus.enc_din) enc_par <= enc_par ^ rom_row(int'(bus.enc_counter));
    bus.enc_dout <= bus.enc_check_en ? enc_par[bus.enc_out_addr] : 1'b0;
  end

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int outs_vec();
    return int'({bus.in_ready, bus.enc_clr, bus.enc_din_valid, bus.enc_din, bus.enc_counter,
                 bus.enc_out_addr, bus.enc_check_en, bus.out_valid, bus.out_data,
                 bus.out_sof, bus.out_eof, bus.frame_done});
  endfunction

  // Monitor: pops the scoreboard on every output bit, tracks readout addresses and frame ends.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_bit", int'({bus.out_data, bus.out_sof, bus.out_eof}), int'(e));
        end
        nout++;
      end
      if (bus.enc_check_en) begin
        check("out_addr", int'(bus.enc_out_addr), exp_addr);
        exp_addr--;
      end
      if (bus.frame_done) begin
        check("frame_out_cnt", nout, FRAME_OUT);
        nout = 0;
        ndone++;
        last_done = cyc;
        exp_addr = 359;
      end
    end
  end

  // Drives one frame; rst_at>=0 aborts it with reset at that index; hold keeps in_valid high afterwards.
  task automatic run_frame(input int pat, input bit toggle, input int rst_at, input bit hold);
    logic [359:0] par;
    int idx, info_cyc, clr_cnt, n;
    bit seen_clr, seen_info;
    logic v, d;
    par = '0; idx = 0; info_cyc = 0; clr_cnt = 0; n = 0;
    seen_clr = 0; seen_info = 0;
    while (idx < 4320 && n < 12000) begin
      @(negedge clk);
      n++;
      if (bus.enc_clr) begin
        if (!seen_clr) check("clr_after_done", int'(cyc > last_done), 1);
        seen_clr = 1;
        clr_cnt++;
        check("clr_counter", int'(bus.enc_counter), 0);
      end
      if (bus.in_ready) begin
        if (!seen_info) begin
          check("clr_len", clr_cnt, 4);
          seen_info = 1;
        end
        if (rst_at >= 0 && idx == rst_at) begin
          check("cnt_at_rst", int'(bus.enc_counter), rst_at);
          rst = 1'b1;
          bus.in_valid = 1'b0;
          @(negedge clk);
          check("rst_zero", outs_vec(), 0);
          rst = 1'b0;
          exp_q.delete();
          nout = 0;
          exp_addr = 359;
          return;
        end
        info_cyc++;
        v = toggle ? ((info_cyc % 2) == 0) : 1'b1;
        d = pat_bit(pat, idx);
        bus.in_valid = v;
        bus.in_data  = d;
        #1;
        check("din_vld", int'(bus.enc_din_valid), int'(v));
        if (v) begin
          check("counter", int'(bus.enc_counter), idx);
          check("din", int'(bus.enc_din), int'(d));
          if (d) par = par ^ rom_row(idx);
          if (SYS) exp_q.push_back('{d: d, sof: (idx == 0), eof: 1'b0});
          idx++;
        end
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
      end
    end
    check("frame_accepted", idx, 4320);
    check("info_len", info_cyc, toggle ? 8640 : 4320);
    for (int k = 0; k < 360; k++)
      exp_q.push_back('{d: par[359 - k], sof: (!SYS && k == 0), eof: (k == 359)});
    if (!hold) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("ready_after_last", int'(bus.in_ready), 0);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (ndone < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_cnt", ndone, target);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", outs_vec(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_ready", int'(bus.in_ready), 0);

    run_frame(0, 1'b0, -1, 1'b0);     // all-zero frame
    wait_done(1);
    run_frame(1, 1'b0, -1, 1'b0);     // single one at index 0
    wait_done(2);
    run_frame(2, 1'b1, -1, 1'b0);     // sparse pattern, alternating stalls
    wait_done(3);
    run_frame(2, 1'b0, 2000, 1'b0);   // aborted by reset at index 2000
    run_frame(0, 1'b0, -1, 1'b0);     // all-zero frame must clear stale parity
    wait_done(4);
    run_frame(3, 1'b0, -1, 1'b1);     // back-to-back pair
    run_frame(4, 1'b0, -1, 1'b0);
    wait_done(6);
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("frame_done_total", ndone, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
